// File: rtl/nrf2401_rx_reader.sv
// nRF2401 ShockBurst receive reader: clocks a frame out of the radio on DR1
// and hands the bytes to the CPU through a small Avalon-MM register window.
module nrf2401_rx_reader #(
   parameter int PAYLOAD_BYTES = 4,
   parameter int CLK_DIV       = 25
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic [1:0] address,
   input  logic       chipselect,
   input  logic       read_n,
   input  logic       write_n,
   input  logic [7:0] writedata,
   output logic [7:0] readdata,
   output logic       irq,
   input  logic       dr1_in,
   input  logic       data_in,
   output logic       clk1_out
);

   localparam int BIT_W  = $clog2(PAYLOAD_BYTES * 8) + 1;
   localparam int BYTE_W = BIT_W - 3;
   localparam int PTR_W  = $clog2(PAYLOAD_BYTES + 1);

   localparam logic [7:0]       DIV_LAST = 8'(CLK_DIV - 1);
   localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(PAYLOAD_BYTES * 8 - 1);
   localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(PAYLOAD_BYTES - 1);

   typedef enum logic [2:0] {
      IDLE,
      SHIFT_HI,
      SHIFT_LO,
      WAIT_DR_LOW,
      READY
   } state_t;

   state_t           state_q, state_d;
   logic [7:0]       div_cnt_q, div_cnt_d;
   logic [BIT_W-1:0] bit_cnt_q, bit_cnt_d;
   logic [7:0]       shift_q, shift_d;
   logic [7:0]       buf_q [PAYLOAD_BYTES];
   logic [7:0]       buf_d [PAYLOAD_BYTES];
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic             frame_ready_q, frame_ready_d;
   logic             overrun_q, overrun_d;
   logic             irq_en_q, irq_en_d;
   logic             irq_q, irq_d;
   logic             clk1_q, clk1_d;

   logic dr1_meta_q, dr1_sync_q, dr1_prev_q;
   logic data_meta_q, data_sync_q;

   logic dr1_rise, wr_en, pop, flush, busy;
   logic [7:0] rd_byte;
   logic unused_wd;

   assign unused_wd = ^{writedata[7:4], writedata[1]};

   // Two-stage synchronisers for the radio lines plus a delayed DR1 for edge detection
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         dr1_meta_q  <= 1'b0;
         dr1_sync_q  <= 1'b0;
         dr1_prev_q  <= 1'b0;
         data_meta_q <= 1'b0;
         data_sync_q <= 1'b0;
      end else begin
         dr1_meta_q  <= dr1_in;
         dr1_sync_q  <= dr1_meta_q;
         dr1_prev_q  <= dr1_sync_q;
         data_meta_q <= data_in;
         data_sync_q <= data_meta_q;
      end
   end

   assign dr1_rise = dr1_sync_q & ~dr1_prev_q;
   assign wr_en    = chipselect & ~write_n;
   assign pop      = chipselect & ~read_n & (address == 2'd0) & frame_ready_q;
   assign flush    = wr_en & (address == 2'd3) & writedata[0];
   assign busy     = (state_q == SHIFT_HI) | (state_q == SHIFT_LO) | (state_q == WAIT_DR_LOW);

   // State register and all datapath flops; reset also drops CLK1 without waiting for a clock
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q       <= IDLE;
         div_cnt_q     <= '0;
         bit_cnt_q     <= '0;
         shift_q       <= '0;
         buf_q         <= '{default: '0};
         rd_ptr_q      <= '0;
         frame_ready_q <= 1'b0;
         overrun_q     <= 1'b0;
         irq_en_q      <= 1'b0;
         irq_q         <= 1'b0;
         clk1_q        <= 1'b0;
      end else begin
         state_q       <= state_d;
         div_cnt_q     <= div_cnt_d;
         bit_cnt_q     <= bit_cnt_d;
         shift_q       <= shift_d;
         buf_q         <= buf_d;
         rd_ptr_q      <= rd_ptr_d;
         frame_ready_q <= frame_ready_d;
         overrun_q     <= overrun_d;
         irq_en_q      <= irq_en_d;
         irq_q         <= irq_d;
         clk1_q        <= clk1_d;
      end
   end

   // Next-state logic: frame capture sequencing, CPU pops, control writes; flush overrides everything
   always_comb begin
      state_d       = state_q;
      div_cnt_d     = div_cnt_q;
      bit_cnt_d     = bit_cnt_q;
      shift_d       = shift_q;
      buf_d         = buf_q;
      rd_ptr_d      = rd_ptr_q;
      frame_ready_d = frame_ready_q;
      overrun_d     = overrun_q;
      irq_en_d      = irq_en_q;
      irq_d         = irq_en_q & frame_ready_q;

      if (wr_en && (address == 2'd1)) begin
         irq_en_d = writedata[3];
         if (writedata[2]) begin
            overrun_d = 1'b0;
         end
      end

      case (state_q)
         IDLE: begin
            if (dr1_rise) begin
               state_d   = SHIFT_HI;
               div_cnt_d = '0;
               bit_cnt_d = '0;
            end
         end
         SHIFT_HI: begin
            if (div_cnt_q == DIV_LAST) begin
               div_cnt_d = '0;
               shift_d   = {shift_q[6:0], data_sync_q};
               state_d   = SHIFT_LO;
            end else begin
               div_cnt_d = div_cnt_q + 8'd1;
            end
         end
         SHIFT_LO: begin
            if (div_cnt_q == DIV_LAST) begin
               div_cnt_d = '0;
               if (bit_cnt_q[2:0] == 3'b111) begin
                  for (int i = 0; i < PAYLOAD_BYTES; i++) begin
                     if (bit_cnt_q[BIT_W-1:3] == BYTE_W'(i)) begin
                        buf_d[i] = shift_q;
                     end
                  end
               end
               if (bit_cnt_q == LAST_BIT) begin
                  state_d = WAIT_DR_LOW;
               end else begin
                  bit_cnt_d = bit_cnt_q + BIT_W'(1);
                  state_d   = SHIFT_HI;
               end
            end else begin
               div_cnt_d = div_cnt_q + 8'd1;
            end
         end
         WAIT_DR_LOW: begin
            if (!dr1_sync_q) begin
               frame_ready_d = 1'b1;
               rd_ptr_d      = '0;
               state_d       = READY;
            end
         end
         READY: begin
            if (dr1_rise) begin
               overrun_d = 1'b1;
            end
            if (pop) begin
               rd_ptr_d = rd_ptr_q + PTR_W'(1);
               if (rd_ptr_q == LAST_PTR) begin
                  frame_ready_d = 1'b0;
                  state_d       = IDLE;
               end
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      if (flush) begin
         state_d       = IDLE;
         frame_ready_d = 1'b0;
         rd_ptr_d      = '0;
         bit_cnt_d     = '0;
         div_cnt_d     = '0;
         overrun_d     = overrun_q;
      end

      clk1_d = (state_d == SHIFT_HI);
   end

   // Register read mux; the data port only shows a byte while a frame is pending
   always_comb begin
      rd_byte = 8'h00;
      for (int i = 0; i < PAYLOAD_BYTES; i++) begin
         if (rd_ptr_q == PTR_W'(i)) begin
            rd_byte = buf_q[i];
         end
      end
      case (address)
         2'd0:    readdata = frame_ready_q ? rd_byte : 8'h00;
         2'd1:    readdata = {4'b0000, irq_en_q, overrun_q, busy, frame_ready_q};
         2'd2:    readdata = frame_ready_q ? (8'(PAYLOAD_BYTES) - 8'(rd_ptr_q)) : 8'h00;
         default: readdata = 8'h00;
      endcase
   end

   assign irq      = irq_q;
   assign clk1_out = clk1_q;

endmodule

// File: tb/tb_nrf2401_rx_reader.sv
// Testbench for nrf2401_rx_reader: a radio model shifts frames out on CLK1 and
// a transaction-level model of the register window predicts every readback.
module tb_nrf2401_rx_reader;

   localparam int PB  = 4;
   localparam int DIV = 4;

   logic       clk = 1'b0;
   logic       reset_n = 1'b1;
   logic [1:0] address = 2'd0;
   logic       chipselect = 1'b0;
   logic       read_n = 1'b1;
   logic       write_n = 1'b1;
   logic [7:0] writedata = 8'h00;
   logic [7:0] readdata;
   logic       irq;
   logic       dr1_in = 1'b0;
   logic       data_in;
   logic       clk1_out;

   nrf2401_rx_reader #(
      .PAYLOAD_BYTES(PB),
      .CLK_DIV(DIV)
   ) dut (
      .clk(clk),
      .reset_n(reset_n),
      .address(address),
      .chipselect(chipselect),
      .read_n(read_n),
      .write_n(write_n),
      .writedata(writedata),
      .readdata(readdata),
      .irq(irq),
      .dr1_in(dr1_in),
      .data_in(data_in),
      .clk1_out(clk1_out)
   );

   // 100 MHz system clock
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail = 0;

   int pulses = 0;
   int falls = 0;
   int high_cycles = 0;
   int pulse_base = 0;
   int high_base = 0;

   // Count CLK1 rising edges
   always @(posedge clk1_out) pulses++;

   // Count CLK1 falling edges; the radio advances its data bit on each one
   always @(negedge clk1_out) falls++;

   // Measure total CLK1 high time in system clock cycles
   always @(negedge clk) if (clk1_out === 1'b1) high_cycles++;

   logic [31:0] radio_bits = 32'h0;
   logic        radio_on = 1'b0;
   int          radio_base = 0;

   function automatic int clampIdx(input int k);
      if (k < 0) return 0;
      if (k > 31) return 31;
      return k;
   endfunction

   assign data_in = radio_on ? radio_bits[31 - clampIdx(falls - radio_base)] : 1'b0;

   logic [7:0] m_buf [PB];
   int         m_rd_ptr = 0;
   logic       m_frame_ready = 1'b0;
   logic       m_overrun = 1'b0;
   logic       m_irq_en = 1'b0;
   logic       m_busy = 1'b0;

   typedef struct {
      logic [31:0] payload;
      logic        irq_en;
      logic [7:0]  exp_status;
      logic        exp_irq;
   } vec_t;

   vec_t vecs [6];

   function automatic logic [7:0] expStatus();
      return {4'b0000, m_irq_en, m_overrun, m_busy, m_frame_ready};
   endfunction

   task automatic modelReset();
      m_rd_ptr      = 0;
      m_frame_ready = 1'b0;
      m_overrun     = 1'b0;
      m_irq_en      = 1'b0;
      m_busy        = 1'b0;
   endtask

   task automatic modelPop(output logic [7:0] e);
      if (m_frame_ready) begin
         e = m_buf[m_rd_ptr];
         m_rd_ptr++;
         if (m_rd_ptr == PB) m_frame_ready = 1'b0;
      end else begin
         e = 8'h00;
      end
   endtask

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      n_checks++;
      if (actual !== expected) begin
         n_fail++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
      end
   endtask

   task automatic busWrite(input logic [1:0] a, input logic [7:0] d);
      @(negedge clk);
      address = a;
      writedata = d;
      chipselect = 1'b1;
      write_n = 1'b0;
      @(negedge clk);
      chipselect = 1'b0;
      write_n = 1'b1;
   endtask

   task automatic busRead(input logic [1:0] a, output logic [7:0] d, output logic ir);
      @(negedge clk);
      address = a;
      chipselect = 1'b1;
      read_n = 1'b0;
      #1 d = readdata;
      @(negedge clk);
      ir = irq;
      chipselect = 1'b0;
      read_n = 1'b1;
   endtask

   task automatic startFrame(input logic [31:0] p);
      @(negedge clk);
      radio_bits = p;
      radio_base = falls;
      radio_on = 1'b1;
      pulse_base = pulses;
      high_base = high_cycles;
      m_busy = 1'b1;
      dr1_in = 1'b1;
   endtask

   task automatic runFrame(input logic [31:0] p, input string tag);
      logic [7:0] st;
      logic       ir;
      int         fr;
      int         irc;
      startFrame(p);
      for (int c = 0; c < PB * 16 * DIV + 40 && (pulses - pulse_base) < PB * 8; c++) @(negedge clk);
      repeat (2 * DIV + 6) @(negedge clk);
      checkOutput({tag, " clk1 pulses"}, pulses - pulse_base, PB * 8);
      checkOutput({tag, " clk1 high cycles"}, high_cycles - high_base, PB * 8 * DIV);
      busRead(2'd1, st, ir);
      checkOutput({tag, " status while dr1 high"}, st, expStatus());
      dr1_in = 1'b0;
      radio_on = 1'b0;
      address = 2'd1;
      chipselect = 1'b1;
      read_n = 1'b0;
      fr = -1;
      irc = -1;
      for (int c = 0; c < 20; c++) begin
         @(negedge clk);
         if (fr < 0 && readdata[0] === 1'b1) fr = c;
         if (irc < 0 && irq === 1'b1) irc = c;
      end
      chipselect = 1'b0;
      read_n = 1'b1;
      m_busy = 1'b0;
      m_frame_ready = 1'b1;
      m_rd_ptr = 0;
      for (int i = 0; i < PB; i++) m_buf[i] = p[31 - 8 * i -: 8];
      checkOutput({tag, " frame_ready seen"}, fr >= 0, 1);
      checkOutput({tag, " irq rise cycle"}, irc, m_irq_en ? fr + 1 : -1);
   endtask

   task automatic popAll(input string tag);
      logic [7:0] d;
      logic [7:0] e;
      logic       ir;
      for (int i = 0; i < PB; i++) begin
         busRead(2'd2, d, ir);
         checkOutput($sformatf("%s remaining %0d", tag, i), d, m_frame_ready ? PB - m_rd_ptr : 0);
         busRead(2'd0, d, ir);
         modelPop(e);
         checkOutput($sformatf("%s byte %0d", tag, i), d, e);
         if (i == PB - 1) begin
            checkOutput({tag, " irq right after last pop"}, ir, m_irq_en);
            @(negedge clk);
            checkOutput({tag, " irq one cycle after last pop"}, irq, 0);
         end
      end
      busRead(2'd1, d, ir);
      checkOutput({tag, " status after pops"}, d, expStatus());
   endtask

   task automatic applyStimulus(input vec_t v, input int idx);
      logic [7:0] st;
      logic       ir;
      string      tag;
      tag = $sformatf("vec%0d", idx);
      busWrite(2'd1, {4'b0000, v.irq_en, 3'b000});
      m_irq_en = v.irq_en;
      runFrame(v.payload, tag);
      busRead(2'd1, st, ir);
      checkOutput({tag, " ready status"}, st, v.exp_status);
      checkOutput({tag, " irq level"}, irq, v.exp_irq);
      popAll(tag);
   endtask

   // Hard time limit so the run always ends
   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: simulation time limit reached, n_fail=%0d", n_fail);
      $fatal(1, "[TB] watchdog");
   end

   // Main test sequence
   initial begin
      logic [7:0]  d;
      logic        ir;
      logic [31:0] p;
      int          base;
      logic        ie;

      #2 reset_n = 1'b0;
      repeat (3) @(negedge clk);
      reset_n = 1'b1;
      modelReset();

      busRead(2'd1, d, ir);
      checkOutput("reset status", d, 8'h00);
      checkOutput("reset clk1", clk1_out, 0);
      checkOutput("reset irq", irq, 0);
      busRead(2'd2, d, ir);
      checkOutput("reset remaining", d, 8'h00);
      busRead(2'd0, d, ir);
      checkOutput("reset data read", d, 8'h00);
      busRead(2'd3, d, ir);
      checkOutput("reset addr3 read", d, 8'h00);

      vecs[0] = '{32'hA53CFF01, 1'b0, 8'h01, 1'b0};
      vecs[1] = '{32'hA53CFF01, 1'b1, 8'h09, 1'b1};
      vecs[2] = '{32'h00000000, 1'b0, 8'h01, 1'b0};
      vecs[3] = '{32'hFFFFFFFF, 1'b1, 8'h09, 1'b1};
      for (int i = 4; i < 6; i++) begin
         ie = 1'($urandom_range(0, 1));
         vecs[i] = '{$urandom, ie, {4'b0000, ie, 3'b001}, ie};
      end
      for (int i = 0; i < 6; i++) applyStimulus(vecs[i], i);

      // second DR1 edge while a frame is pending
      busWrite(2'd1, 8'h00);
      m_irq_en = 1'b0;
      runFrame($urandom, "ovr");
      base = pulses;
      @(negedge clk);
      dr1_in = 1'b1;
      repeat (30) @(negedge clk);
      checkOutput("ovr no clk1 pulses", pulses - base, 0);
      m_overrun = 1'b1;
      busRead(2'd1, d, ir);
      checkOutput("ovr status", d, expStatus());
      busWrite(2'd1, 8'h04);
      m_overrun = 1'b0;
      busRead(2'd1, d, ir);
      checkOutput("ovr cleared status", d, expStatus());
      dr1_in = 1'b0;
      repeat (4) @(negedge clk);
      popAll("ovr");

      // flush after 13 bits of a frame
      busWrite(2'd1, 8'h08);
      m_irq_en = 1'b1;
      p = $urandom;
      startFrame(p);
      for (int c = 0; c < 400 && (pulses - pulse_base) < 14; c++) @(negedge clk);
      checkOutput("flush clk1 high before", clk1_out, 1);
      address = 2'd3;
      writedata = 8'h01;
      chipselect = 1'b1;
      write_n = 1'b0;
      @(posedge clk);
      #1 checkOutput("flush clk1 low next cycle", clk1_out, 0);
      @(negedge clk);
      chipselect = 1'b0;
      write_n = 1'b1;
      m_busy = 1'b0;
      m_frame_ready = 1'b0;
      m_rd_ptr = 0;
      base = pulses;
      repeat (20) @(negedge clk);
      checkOutput("flush no further pulses", pulses - base, 0);
      busRead(2'd1, d, ir);
      checkOutput("flush status", d, expStatus());
      busRead(2'd0, d, ir);
      checkOutput("flush data read", d, 8'h00);
      busRead(2'd2, d, ir);
      checkOutput("flush remaining", d, 8'h00);
      dr1_in = 1'b0;
      radio_on = 1'b0;
      repeat (5) @(negedge clk);
      runFrame($urandom, "refr");
      popAll("refr");

      // asynchronous reset in the middle of a CLK1 high phase
      busWrite(2'd1, 8'h08);
      m_irq_en = 1'b1;
      startFrame($urandom);
      for (int c = 0; c < 400 && (pulses - pulse_base) < 5; c++) @(negedge clk);
      checkOutput("rst clk1 high before", clk1_out, 1);
      #2 reset_n = 1'b0;
      #1 checkOutput("rst clk1 async low", clk1_out, 0);
      checkOutput("rst irq low", irq, 0);
      dr1_in = 1'b0;
      radio_on = 1'b0;
      modelReset();
      repeat (3) @(negedge clk);
      reset_n = 1'b1;
      busRead(2'd1, d, ir);
      checkOutput("rst status", d, expStatus());
      busRead(2'd2, d, ir);
      checkOutput("rst remaining", d, 8'h00);
      busRead(2'd0, d, ir);
      checkOutput("rst data read", d, 8'h00);
      base = pulses;
      repeat (20) @(negedge clk);
      checkOutput("rst no pulses", pulses - base, 0);
      checkOutput("rst clk1 stays low", clk1_out, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
